// File: rtl/board_readout.sv
// board_readout
//   Debounce-free button readout of a 16x16 board state. Three pushbuttons are
//   synchronized and edge-detected. BtnU/BtnD step the viewed row, and BtnC
//   starts a full-board dump over a valid/ready handshake. Led mirrors the
//   viewed row.
//
//   Optional build macro: BOARD_READOUT_AUTO_SCAN_EN
//     Adds the auto_scan input and a row scan counter. While auto_scan=1 and
//     enable=1, row_index advances every SCAN_DIV clk cycles, wrapping 15 -> 0,
//     and BtnU/BtnD are ignored.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      readout active; low ignores buttons and aborts a dump
//   BtnU/BtnD   raw buttons: viewed row up (decrement) / down (increment)
//   BtnC        raw button: start full-board dump
//   board_in    256-bit board, row r at [16r+15:16r]
//   Led         registered copy of the viewed row
//   row_index   viewed row
//   row_valid   dump beat valid
//   row_ready   dump beat ready from the sink
//   row_addr    dump beat row number
//   row_data    dump beat row contents
//   dump_done   one-cycle pulse after the last beat transfers
//   auto_scan   (macro builds only) selects auto-scan mode
//
// Dump FSM
//   state | meaning
//   IDLE  | no dump in progress, row_valid low
//   DUMP  | presenting beat row_addr, row_valid high
module board_readout #(
  parameter int SCAN_DIV = 25000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnC,
  input  logic [255:0] board_in,
  output logic [15:0]  Led,
  output logic [3:0]   row_index,
  output logic         row_valid,
  input  logic         row_ready,
  output logic [3:0]   row_addr,
  output logic [15:0]  row_data,
  output logic         dump_done
`ifdef BOARD_READOUT_AUTO_SCAN_EN
  ,
  input  logic         auto_scan
`endif
);

  typedef enum logic {IDLE, DUMP} dump_state_t;

  dump_state_t state;

  function automatic logic [15:0] row_of(input logic [255:0] b, input logic [3:0] r);
    return b[{r, 4'b0000} +: 16];
  endfunction

  // Button path: bit 0 = BtnU, bit 1 = BtnD, bit 2 = BtnC
  logic [2:0] btn_raw, sync1, sync2, btn_prev, btn_evt;
  assign btn_raw = {BtnC, BtnD, BtnU};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_prev <= '0;
      btn_evt  <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_prev <= sync2;
      btn_evt  <= sync2 & ~btn_prev;
    end
  end

  logic scan_mode;
  logic scan_step;

`ifdef BOARD_READOUT_AUTO_SCAN_EN
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] scan_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
    end else if (!auto_scan) begin
      scan_cnt <= '0;
    end else if (enable) begin
      if (scan_cnt == SCAN_LAST) scan_cnt <= '0;
      else                       scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign scan_mode = auto_scan;
  assign scan_step = auto_scan & enable & (scan_cnt == SCAN_LAST);
`else
  // SCAN_DIV only matters in the auto-scan build; referenced here so the
  // manual-only build keeps the same parameter list without a dangling name.
  logic unused_scan_div;
  assign unused_scan_div = ^SCAN_DIV;
  assign scan_mode = 1'b0;
  assign scan_step = 1'b0;
`endif

  // Manual steps only count in IDLE with the block enabled.
  logic man_ok, step_up, step_dn;
  assign man_ok  = enable & ~scan_mode & (state == IDLE);
  assign step_up = man_ok & btn_evt[0] & ~btn_evt[1];
  assign step_dn = man_ok & btn_evt[1] & ~btn_evt[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_index <= '0;
    end else if (scan_step) begin
      row_index <= row_index + 4'd1;
    end else if (step_up) begin
      if (row_index != 4'd0) row_index <= row_index - 4'd1;
    end else if (step_dn) begin
      if (row_index != 4'd15) row_index <= row_index + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Led <= '0;
    else       Led <= row_of(board_in, row_index);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row_valid <= 1'b0;
      row_addr  <= '0;
      row_data  <= '0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && btn_evt[2]) begin
            state     <= DUMP;
            row_valid <= 1'b1;
            row_addr  <= 4'd0;
            row_data  <= row_of(board_in, 4'd0);
          end
        end
        DUMP: begin
          // Losing enable wins over a simultaneous transfer: abort silently.
          if (!enable) begin
            state     <= IDLE;
            row_valid <= 1'b0;
          end else if (row_ready) begin
            if (row_addr == 4'd15) begin
              state     <= IDLE;
              row_valid <= 1'b0;
              dump_done <= 1'b1;
            end else begin
              row_addr <= row_addr + 4'd1;
              row_data <= row_of(board_in, row_addr + 4'd1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          row_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/board_readout.md
BOARD_READOUT -- requirements
Module: board_readout

Interface
REQ-001 Parameter SCAN_DIV, default 25000000, is the number of clk cycles per auto-scan row step.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  readout active; when low, buttons are ignored and any dump is aborted.
REQ-005 BtnU  input  1  raw pushbutton; step viewed row up (index decrement).
REQ-006 BtnD  input  1  raw pushbutton; step viewed row down (index increment).
REQ-007 BtnC  input  1  raw pushbutton; start a full-board dump.
REQ-008 board_in  input  256  board state; row r occupies bits [16r+15:16r], and bit c of a row is column c.
REQ-009 Led  output  16  registered copy of the currently viewed row.
REQ-010 row_index  output  4  currently viewed row.
REQ-011 row_valid  output  1  dump handshake valid.
REQ-012 row_ready  input  1  dump handshake ready from the sink.
REQ-013 row_addr  output  4  row number of the current dump beat.
REQ-014 row_data  output  16  row contents of the current dump beat.
REQ-015 dump_done  output  1  one-cycle pulse after the last dump beat transfers.
REQ-016 auto_scan  input  1  exists only with AUTO_SCAN_EN; selects auto-scan mode.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer followed by a registered rising-edge detector, giving one press event per press.
REQ-018 A button first sampled high at edge N SHALL produce its press event at edge N+2, and its effect SHALL be visible at edge N+3.
REQ-019 In manual mode, a BtnU event SHALL decrement row_index, saturating at 0.
REQ-020 In manual mode, a BtnD event SHALL increment row_index, saturating at 15.
REQ-021 If BtnU and BtnD events occur in the same cycle, row_index SHALL not change.
REQ-022 Led SHALL equal the board_in row selected by row_index, registered with 1 cycle of latency after row_index or board_in changes.
REQ-023 The dump FSM SHALL have exactly two states, IDLE and DUMP.
REQ-024 IDLE -> DUMP SHALL occur on a BtnC event while enable=1, with row_addr set to 0.
REQ-025 In DUMP, row_valid SHALL be 1 and row_data SHALL equal board_in row row_addr, captured at beat start.
REQ-026 While row_valid=1 and row_ready=0, row_data and row_addr SHALL hold stable.
REQ-027 A beat transfers on any edge where row_valid and row_ready are both 1; after a transfer, row_addr SHALL increment.
REQ-028 When the beat with row_addr=15 transfers, the FSM SHALL return to IDLE, drop row_valid, and pulse dump_done for 1 cycle.
REQ-029 A dump with continuous ready SHALL take exactly 16 cycles.
REQ-030 In DUMP, BtnU, BtnD and BtnC events SHALL be ignored.
REQ-031 Deasserting enable in DUMP SHALL go to IDLE on the next edge, with row_valid=0 and no dump_done pulse.
REQ-032 In IDLE, row_valid SHALL be 0.

Reset
REQ-033 Asserting reset SHALL immediately clear Led, row_index, row_valid, row_addr, row_data, dump_done, the synchronizers, the edge detectors and the scan counter.
REQ-034 Asserting reset SHALL immediately force the FSM to IDLE.
REQ-035 Reset asserted mid-dump SHALL abort the dump without a dump_done pulse.

Configuration
REQ-036 Macro BOARD_READOUT_AUTO_SCAN_EN, when defined, SHALL add the auto_scan port and a counter of width ceil(log2(SCAN_DIV)).
REQ-037 With the macro defined, auto_scan=1 and enable=1 SHALL advance row_index by 1 every SCAN_DIV cycles, wrapping 15 -> 0.
REQ-038 With the macro defined, BtnU and BtnD SHALL be ignored while auto_scan=1.
REQ-039 With the macro defined, the scan counter SHALL clear whenever auto_scan=0.
REQ-040 Without the macro, the port and counter SHALL be absent and the block SHALL operate in manual mode only.

Verification
REQ-041 After reset, a BtnD press high for 5 cycles -> row_index=1 on exactly edge N+3 with a single step; Led = board_in[31:16] one cycle later.
REQ-042 With row_index=0, press BtnU -> row_index stays 0; with row_index=15, press BtnD -> row_index stays 15; BtnU and BtnD pressed in the same cycle -> no change.
REQ-043 With board row r = 16'h0100+r, press BtnC and hold row_ready=1 -> 16 beats with addr 0..15 and data 16'h0100..16'h010F, then dump_done high for 1 cycle.
REQ-044 During a dump, hold row_ready=0 for 4 cycles at beat 7 -> addr=7 and data held stable; after ready returns, beats 8..15 complete.
REQ-045 Drop enable at beat 3, or assert reset at beat 9 -> row_valid=0 next edge (immediately for reset), FSM in IDLE, no dump_done pulse.
REQ-046 With the macro defined, SCAN_DIV=4 and auto_scan=1 -> row_index sequence 0,1,...,15,0 with a step every 4 cycles.
